// File: rtl/lru_arbiter_if.sv
// Request/grant bundle between the requester logic and the LRU arbiter.
// The master side drives req/tick; the arbiter (slave) drives grant and status.
interface lru_arbiter_if;
  logic [3:0] req;
  logic       tick;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic [7:0] order;
  logic       timeout;

  modport master (
    output req,
    output tick,
    input  gnt,
    input  gnt_vld,
    input  gnt_id,
    input  order,
    input  timeout
  );

  modport slave (
    input  req,
    input  tick,
    output gnt,
    output gnt_vld,
    output gnt_id,
    output order,
    output timeout
  );
endinterface

// File: rtl/lru_arbiter.sv
// Four-way least-recently-used arbiter with a tick-based hold limit.
// order keeps slot0 as LRU and slot3 as MRU; each grant moves its winner to slot3.
module lru_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input logic         clk,
  input logic         rst,
  lru_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0][1:0]  order_q;
  logic [3:0]       gnt_q;
  logic             gnt_vld_q;
  logic [1:0]       gnt_id_q;
  logic             timeout_q;

  logic [1:0]       win_pos;
  logic [1:0]       win_id;
  logic [3:0][1:0]  order_next;
  logic [3:0]       seen;

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.order   = order_q;
  assign bus.timeout = timeout_q;

  // Scan from LRU to MRU; only meaningful when some req bit is set.
  always_comb begin
    win_pos = 2'd3;
    if (bus.req[order_q[0]])      win_pos = 2'd0;
    else if (bus.req[order_q[1]]) win_pos = 2'd1;
    else if (bus.req[order_q[2]]) win_pos = 2'd2;
    win_id = order_q[win_pos];
  end

  // Slots at or above the winner's old position shift down one; winner becomes MRU.
  always_comb begin
    order_next    = order_q;
    order_next[0] = (win_pos == 2'd0) ? order_q[1] : order_q[0];
    order_next[1] = (win_pos <= 2'd1) ? order_q[2] : order_q[1];
    order_next[2] = (win_pos <= 2'd2) ? order_q[3] : order_q[2];
    order_next[3] = win_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
      timeout_q <= 1'b0;
      hold_cnt  <= '0;
      order_q   <= 8'hE4;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state     <= GRANT;
            gnt_q     <= 4'b0001 << win_id;
            gnt_vld_q <= 1'b1;
            gnt_id_q  <= win_id;
            hold_cnt  <= '0;
            order_q   <= order_next;
          end
        end
        GRANT: begin
          // A release wins over a simultaneous final tick, so no timeout then.
          if (!bus.req[gnt_id_q]) begin
            state     <= GAP;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
          end else if (bus.tick) begin
            if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
              state     <= GAP;
              gnt_q     <= '0;
              gnt_vld_q <= 1'b0;
              timeout_q <= 1'b1;
            end else if (hold_cnt != '1) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    seen             = '0;
    seen[order_q[0]] = 1'b1;
    seen[order_q[1]] = 1'b1;
    seen[order_q[2]] = 1'b1;
    seen[order_q[3]] = 1'b1;
  end

  a_order_perm: assert property (@(posedge clk) disable iff (rst) (&seen));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_vld:    assert property (@(posedge clk) disable iff (rst) (gnt_vld_q == (|gnt_q)));

endmodule
